// File: rtl/ov7670_sccb_config_if.sv
// Bus bundle between the OV7670 configuration sequencer, its register ROM and the SCCB pins.
// master = the sequencer; slave = the ROM / pad / control side that faces it.
interface ov7670_sccb_config_if;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        sioc;
  logic        siod_o;
  logic        siod_oe;
  logic        siod_i;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, rom_dout, siod_i,
    output rom_addr, sioc, siod_o, siod_oe, busy, done, err
  );

  modport slave (
    output start, rom_dout, siod_i,
    input  rom_addr, sioc, siod_o, siod_oe, busy, done, err
  );
endinterface

// File: rtl/ov7670_sccb_config.sv
// OV7670 configuration sequencer: walks the register ROM and issues one SCCB 3-phase write per entry.
// Define SCCB_ACK_CHK_EN to sample the don't-care bits and flag NACKs on err.
module ov7670_sccb_config #(
  parameter int unsigned CLK_FREQ_HZ  = 25_000_000,
  parameter int unsigned SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter int unsigned DELAY_CYCLES = 250_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ov7670_sccb_config_if.master        bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, DELAY, TX_START, TX_BITS, TX_STOP, GAP, DONE
  } state_e;

  localparam int unsigned Q     = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int unsigned PHASE = 4 * Q;
  localparam int          CW    = $clog2(PHASE);
  localparam int          DW    = $clog2(DELAY_CYCLES + 1);

  localparam logic [CW-1:0] Q1       = CW'(Q);
  localparam logic [CW-1:0] Q2       = CW'(2 * Q);
  localparam logic [CW-1:0] Q3       = CW'(3 * Q);
  localparam logic [CW-1:0] PH_LAST  = CW'(PHASE - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(DELAY_CYCLES - 1);
  localparam logic [4:0]    BIT_LAST = 5'd26;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  state_e         state, state_nx;
  logic [CW-1:0]  ph_cnt;
  logic [4:0]     bit_cnt;
  logic [DW-1:0]  dly_cnt;
  logic [23:0]    shreg;
  logic [7:0]     rom_addr_q;
  logic           sioc_q, siod_q, oe_q;
  logic           sioc_nx, siod_nx, oe_nx;
  logic           err_q;
  logic           ph_end, dc_slot, accept, advance;

  assign ph_end  = (ph_cnt == PH_LAST);
  // Slots 9, 18 and 27 (zero-based 8, 17, 26) carry the slave's ack bit.
  assign dc_slot = (bit_cnt == 5'd8) || (bit_cnt == 5'd17) || (bit_cnt == 5'd26);
  assign accept  = bus.start && ((state == IDLE) || (state == DONE));
  assign advance = ((state == DELAY) && (dly_cnt == DLY_LAST)) ||
                   ((state == GAP) && ph_end);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_nx = state;
    sioc_nx  = 1'b1;
    siod_nx  = 1'b1;
    oe_nx    = 1'b1;
    unique case (state)
      IDLE, DONE: if (bus.start) state_nx = FETCH;
      FETCH:      state_nx = DECODE;
      DECODE: begin
        if (bus.rom_dout == END_MARK || rom_addr_q == 8'hFF) state_nx = DONE;
        else if (bus.rom_dout == DELAY_MARK)                 state_nx = DELAY;
        else                                                 state_nx = TX_START;
      end
      DELAY:    if (dly_cnt == DLY_LAST) state_nx = FETCH;
      TX_START: begin
        sioc_nx = (ph_cnt < Q3);
        siod_nx = (ph_cnt < Q1);
        if (ph_end) state_nx = TX_BITS;
      end
      TX_BITS: begin
        sioc_nx = (ph_cnt >= Q2);
        siod_nx = dc_slot | shreg[23];
        oe_nx   = ~dc_slot;
        if (ph_end && bit_cnt == BIT_LAST) state_nx = TX_STOP;
      end
      TX_STOP: begin
        sioc_nx = (ph_cnt >= Q1);
        siod_nx = (ph_cnt >= Q3);
        if (ph_end) state_nx = GAP;
      end
      GAP:     if (ph_end) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
  end

  // Pin drivers are registered so SIOC/SIOD never glitch; the waveform trails the state by one clock.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      ph_cnt     <= '0;
      bit_cnt    <= '0;
      dly_cnt    <= '0;
      shreg      <= '0;
      rom_addr_q <= '0;
      sioc_q     <= 1'b1;
      siod_q     <= 1'b1;
      oe_q       <= 1'b1;
    end else begin
      sioc_q <= sioc_nx;
      siod_q <= siod_nx;
      oe_q   <= oe_nx;

      if (state == TX_START || state == TX_BITS || state == TX_STOP || state == GAP)
        ph_cnt <= ph_end ? '0 : ph_cnt + 1'b1;
      else
        ph_cnt <= '0;

      if (state == TX_BITS && ph_end)
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

      dly_cnt <= (state == DELAY && dly_cnt != DLY_LAST) ? dly_cnt + 1'b1 : '0;

      if (state == DECODE)
        shreg <= {DEV_ADDR, bus.rom_dout};
      else if (state == TX_BITS && ph_end && !dc_slot)
        shreg <= {shreg[22:0], 1'b0};

      if (accept)       rom_addr_q <= '0;
      else if (advance) rom_addr_q <= rom_addr_q + 1'b1;
    end
  end

`ifdef SCCB_ACK_CHK_EN
  // Ack is sampled where SIOC rises inside a don't-care slot; a 1 there is a NACK.
  always_ff @(posedge clk) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= 1'b0;
    else if (state == TX_BITS && dc_slot && ph_cnt == Q2 && bus.siod_i)
      err_q <= 1'b1;
  end
`else
  logic siod_i_unused;
  assign siod_i_unused = bus.siod_i;
  assign err_q         = 1'b0;
`endif

  assign bus.rom_addr = rom_addr_q;
  assign bus.sioc     = sioc_q;
  assign bus.siod_o   = siod_q;
  assign bus.siod_oe  = oe_q;
  assign bus.busy     = (state != IDLE) && (state != DONE);
  assign bus.done     = (state == DONE);
  assign bus.err      = err_q;

endmodule

// File: doc/ov7670_sccb_config.md
Name: ov7670_sccb_config

Overview:
Camera configuration sequencer directly downstream of the OV7670 register ROM. On `start` it walks the ROM from address 0. Each 16-bit entry {reg[15:8], val[7:0]} becomes one SCCB 3-phase write to the sensor. Two entries are special: 16'hFFF0 inserts a settle delay, and 16'hFFFF ends the sequence. It sits between the ROM and the sensor's SIOC/SIOD pins. It raises `done` so the capture path can start.

Parameters:
CLK_FREQ_HZ, 25_000_000, system clock frequency
SCCB_FREQ_HZ, 100_000, SIOC frequency; quarter period Q = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ), truncated (62 at defaults)
DEV_ADDR, 8'h42, SCCB write ID
DELAY_CYCLES, 250_000, clock cycles waited on a 16'hFFF0 entry (10 ms at defaults)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
start  in  1  single-cycle pulse; begins a sequence from address 0
rom_addr  out  8  ROM address
rom_dout  in  16  ROM data; valid 1 clock after rom_addr changes (registered ROM)
sioc  out  1  SCCB clock
siod_o  out  1  SCCB data out
siod_oe  out  1  1 = drive siod_o onto the pin; 0 = release (external pull-up)
siod_i  in  1  SCCB data in (used only with the optional feature)
busy  out  1  high from the accepted start until done
done  out  1  sticky high after the end marker; cleared by start or reset
err  out  1  sticky NACK flag (optional feature)

Behaviour:
- Reset values: rom_addr=0, sioc=1, siod_o=1, siod_oe=1, busy=0, done=0, err=0, FSM=IDLE, all counters 0. A reset mid-transaction aborts on the next clock; the bus returns high with no stop condition.
- FSM states: IDLE, FETCH, DECODE, DELAY, TX_START, TX_BITS, TX_STOP, GAP, DONE.
- IDLE or DONE + start: set rom_addr=0, busy=1, done=0, err=0, then go to FETCH. A start seen in any other state is ignored.
- FETCH: wait 1 clock for the ROM latency, then go to DECODE.
- DECODE, by value of rom_dout:
  - 16'hFFFF, or rom_addr==255 (wrap guard, entry not executed) → DONE. In DONE: busy=0, done=1.
  - 16'hFFF0 → DELAY. Bus stays idle for exactly DELAY_CYCLES clocks, then rom_addr+1 and go to FETCH.
  - any other value → latch shift reg = {DEV_ADDR, rom_dout[15:8], rom_dout[7:0]}, then go to TX_START.
- TX_START (4Q clocks): siod_o=0 at Q1 while sioc=1; sioc=0 at Q3.
- TX_BITS: 27 bit slots, each 4Q clocks.
  - sioc low for the first 2Q of each slot, high for the last 2Q.
  - siod changes only at the start of a slot; bits are sent MSB first.
  - Slots 9, 18 and 27 are the don't-care bit: siod_oe=0 for the whole slot.
- TX_STOP (4Q clocks): siod_o=0 with sioc low; sioc=1 at Q1; siod_o=1 at Q3.
- GAP: 4Q clocks of idle bus, then rom_addr+1 and go to FETCH.
- One write transaction is 4Q + 108Q + 4Q + 4Q = 120Q clocks plus the 2 clocks of FETCH/DECODE.
- rom_addr changes only on the FETCH entry transitions listed above.

Optional Feature:
SCCB_ACK_CHK_EN
- Defined: siod_i is sampled at the rising SIOC edge of slots 9, 18 and 27. If any sample is 1 (NACK), err is set and stays set until the next start or reset. The transaction still completes and the sequence continues.
- Undefined: siod_i is ignored and err is tied to 0. Port list and timing are identical in both builds.

Test Plan:
- Reset with Q=2 (CLK 800k/SCCB 100k) → sioc=1, siod_o=1, siod_oe=1, busy=0, done=0, rom_addr=0; bus static for 1000 clocks without start.
- ROM model {0:16'h1204, 1:16'hFFFF}, pulse start → one transaction decoded on sioc rising edges as 0x42, 0x12, 0x04 with siod_oe=0 in slots 9/18/27; done=1, busy=0 at 120Q+4 clocks ±2; rom_addr ends at 1.
- ROM {0:16'hFFF0, 1:16'h1180, 2:16'hFFFF}, DELAY_CYCLES=100 → no sioc edges for 100 clocks after DECODE, then a 0x42/0x11/0x80 write, then done.
- start pulsed mid-transaction → ignored, bitstream unchanged. start pulsed after done → done clears the next clock and the sequence replays from rom_addr=0.
- rst_n low during TX_BITS slot 12 → next clock sioc=1, siod_o=1, busy=0. Following start → clean full sequence.
- SCCB_ACK_CHK_EN defined, siod_i held 1 during slot 18 → err=1 after that slot, sequence still reaches done. Held 0 throughout → err=0.
